// File: rtl/dcm_lock_supervisor_if.sv
// Control and status bundle for the DCM lock supervisor.
// Signalling model: there is no valid/ready handshake on this bundle.
//   locked is a level from the DCM and is asynchronous to the master clock.
//   restart and fault_clr are single-cycle request pulses, sampled on every
//   rising master-clock edge. All status signals are registered levels that
//   change only on a master-clock edge or on asynchronous reset.
// The supervisor consumes the bundle through the slave modport; whoever
// drives the DCM status and requests uses the master modport.
interface dcm_lock_supervisor_if #(
    parameter int CNT_W = 16
);
    logic             locked;
    logic             restart;
    logic             fault_clr;
    logic             dcm_rst;
    logic             wb_rst_out;
    logic             ready;
    logic             fault;
    logic [2:0]       state;
    logic [7:0]       retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        output locked, restart, fault_clr,
        input  dcm_rst, wb_rst_out, ready, fault, state, retry_cnt, loss_cnt
    );

    modport slave (
        input  locked, restart, fault_clr,
        output dcm_rst, wb_rst_out, ready, fault, state, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/dcm_lock_supervisor.sv
// DCM lock supervisor: pulses the DCM reset, waits for LOCKED, qualifies the
// lock for a stable period, then releases the Wishbone-domain reset. A lock
// loss while running re-asserts the Wishbone reset and re-sequences the DCM.
// Too many consecutive failed lock attempts park the block in FAULT until a
// fault_clr pulse. The state register is exported on bus.state for debug.
module dcm_lock_supervisor #(
    parameter int RST_CYCLES    = 128,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 2048,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 16
) (
    input  logic                 wb_clk_master,
    input  logic                 reset,
    dcm_lock_supervisor_if.slave bus
);

    typedef enum logic [2:0] {
        S_RST_DCM   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [8:0]       RETRY_LIMIT = 9'(MAX_RETRIES);

    logic             sync_1;
    logic             locked_s;
    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_n;
    logic [7:0]       retry_q;
    logic [7:0]       retry_n;
    logic [8:0]       retry_inc;
    logic [CNT_W-1:0] loss_q;
    logic [CNT_W-1:0] loss_n;
    logic             loss_event;
    logic             seq_restart;
    logic             dcm_rst_q;
    logic             wb_rst_q;
    logic             ready_q;
    logic             fault_q;

    // Two-flop synchronizer for the asynchronous DCM LOCKED status.
    always_ff @(posedge wb_clk_master or posedge reset) begin
        if (reset) begin
            sync_1   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_1   <= bus.locked;
            locked_s <= sync_1;
        end
    end

    // Next-state, retry/loss bookkeeping; fault_clr outranks restart, which
    // outranks lock-loss and timeout transitions.
    always_comb begin
        state_n     = state_q;
        retry_n     = retry_q;
        loss_event  = 1'b0;
        seq_restart = 1'b0;
        retry_inc   = {1'b0, retry_q} + 9'd1;

        if (state_q == S_FAULT) begin
            if (bus.fault_clr) begin
                state_n = S_RST_DCM;
                retry_n = 8'd0;
            end
        end else if (bus.fault_clr || bus.restart) begin
            // A forced restart is not a lock loss, but a loss seen in the
            // same cycle while running is still counted.
            state_n     = S_RST_DCM;
            seq_restart = 1'b1;
            loss_event  = (state_q == S_RUN) && !locked_s;
            if (bus.fault_clr) begin
                retry_n = 8'd0;
            end
        end else begin
            case (state_q)
                S_RST_DCM: begin
                    if (timer_q == RST_LAST) begin
                        state_n = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_n = S_STABLE;
                    end else if (timer_q == LOCK_LAST) begin
                        retry_n = retry_inc[8] ? 8'hFF : retry_inc[7:0];
                        state_n = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RST_DCM;
                    end
                end
                S_STABLE: begin
                    // A glitch during qualification is not a failed attempt.
                    if (!locked_s) begin
                        state_n = S_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_n = S_RUN;
                        retry_n = 8'd0;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_n    = S_RST_DCM;
                        loss_event = 1'b1;
                    end
                end
                default: state_n = S_RST_DCM;
            endcase
        end

        loss_n  = (loss_event && (loss_q != '1)) ? loss_q + CNT_W'(1) : loss_q;
        timer_n = ((state_n != state_q) || seq_restart) ? '0 : timer_q + CNT_W'(1);
    end

    // State, timer, counters and registered output decodes.
    always_ff @(posedge wb_clk_master or posedge reset) begin
        if (reset) begin
            state_q   <= S_RST_DCM;
            timer_q   <= '0;
            retry_q   <= 8'd0;
            loss_q    <= '0;
            dcm_rst_q <= 1'b1;
            wb_rst_q  <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            retry_q   <= retry_n;
            loss_q    <= loss_n;
            dcm_rst_q <= (state_n == S_RST_DCM) || (state_n == S_FAULT);
            wb_rst_q  <= (state_n != S_RUN);
            ready_q   <= (state_n == S_RUN);
            fault_q   <= (state_n == S_FAULT);
        end
    end

    assign bus.dcm_rst    = dcm_rst_q;
    assign bus.wb_rst_out = wb_rst_q;
    assign bus.ready      = ready_q;
    assign bus.fault      = fault_q;
    assign bus.state      = state_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.loss_cnt   = loss_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Bench for dcm_lock_supervisor with short sequencing parameters.
module tb_dcm_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 16;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 3;
    localparam int CNT_W         = 8;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcm_lock_supervisor_if #(.CNT_W(CNT_W)) bus ();

    dcm_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) dut (
        .wb_clk_master (clk),
        .reset         (rst),
        .bus           (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // Phase plus a countdown of clocks left in the phase; LOCKED history
    // queue gives the value the supervisor sees two clocks later.
    int m_phase;
    int m_left;
    int m_retry;
    int m_loss;
    bit hist[$];

    task automatic enter(input int p);
        m_phase = p;
        case (p)
            P_RST:    m_left = RST_CYCLES;
            P_WAIT:   m_left = LOCK_TIMEOUT;
            P_STABLE: m_left = STABLE_CYCLES;
            default:  m_left = 0;
        endcase
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        m_retry = 0;
        m_loss  = 0;
        enter(P_RST);
    endtask

    task automatic add_loss();
        if (m_loss < (1 << CNT_W) - 1) m_loss++;
    endtask

    task automatic model_step(input bit l, input bit rs, input bit fc);
        bit ls;
        ls = hist.pop_front();
        hist.push_back(l);
        if (m_phase == P_FAULT) begin
            if (fc) begin
                m_retry = 0;
                enter(P_RST);
            end
            return;
        end
        if (fc || rs) begin
            if (m_phase == P_RUN && !ls) add_loss();
            if (fc) m_retry = 0;
            enter(P_RST);
            return;
        end
        m_left--;
        case (m_phase)
            P_RST: if (m_left == 0) enter(P_WAIT);
            P_WAIT: begin
                if (ls) enter(P_STABLE);
                else if (m_left == 0) begin
                    if (m_retry < 255) m_retry++;
                    enter((m_retry == MAX_RETRIES) ? P_FAULT : P_RST);
                end
            end
            P_STABLE: begin
                if (!ls) enter(P_WAIT);
                else if (m_left == 0) begin
                    m_retry = 0;
                    enter(P_RUN);
                end
            end
            P_RUN: begin
                if (!ls) begin
                    add_loss();
                    enter(P_RST);
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        check("state",      32'(bus.state),      32'(m_phase));
        check("dcm_rst",    32'(bus.dcm_rst),    32'(m_phase == P_RST || m_phase == P_FAULT));
        check("wb_rst_out", 32'(bus.wb_rst_out), 32'(m_phase != P_RUN));
        check("ready",      32'(bus.ready),      32'(m_phase == P_RUN));
        check("fault",      32'(bus.fault),      32'(m_phase == P_FAULT));
        check("retry_cnt",  32'(bus.retry_cnt),  32'(m_retry));
        check("loss_cnt",   32'(bus.loss_cnt),   32'(m_loss));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step(bus.locked, bus.restart, bus.fault_clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input bit l);
        bus.locked    = l;
        bus.restart   = 1'b0;
        bus.fault_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    task automatic wait_phase(input int target, input int limit);
        int n = 0;
        while (m_phase != target && n < limit) begin
            tick();
            n++;
        end
        check("wait_phase_budget", 32'(m_phase), 32'(target));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       locked;
        logic [2:0] st;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl[22];

    task automatic fill(input int first, input int last, input logic l,
                        input logic [2:0] s, input logic [7:0] lc);
        for (int i = first; i <= last; i++) tbl[i] = '{l, s, lc};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.locked    = 1'b0;
        bus.restart   = 1'b0;
        bus.fault_clr = 1'b0;

        // Clean lock, then a one-clock lock drop while running.
        fill(0, 2, 1'b1, 3'd0, 8'd0);
        fill(3, 3, 1'b1, 3'd1, 8'd0);
        fill(4, 11, 1'b1, 3'd2, 8'd0);
        fill(12, 13, 1'b1, 3'd3, 8'd0);
        fill(14, 14, 1'b0, 3'd3, 8'd0);
        fill(15, 15, 1'b1, 3'd3, 8'd0);
        fill(16, 19, 1'b1, 3'd0, 8'd1);
        fill(20, 20, 1'b1, 3'd1, 8'd1);
        fill(21, 21, 1'b1, 3'd2, 8'd1);

        do_reset(1'b1);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_dcm", 32'(bus.dcm_rst), 32'd1);
        for (int i = 0; i < 22; i++) begin
            bus.locked = tbl[i].locked;
            tick();
            check("tbl_state", 32'(bus.state), 32'(tbl[i].st));
            check("tbl_dcm_rst", 32'(bus.dcm_rst), 32'(tbl[i].st == 3'd0));
            check("tbl_ready", 32'(bus.ready), 32'(tbl[i].st == 3'd3));
            check("tbl_loss", 32'(bus.loss_cnt), 32'(tbl[i].loss));
        end

        // No lock: three failed attempts then FAULT.
        do_reset(1'b0);
        repeat (20) tick();
        check("t2_retry1", 32'(bus.retry_cnt), 32'd1);
        check("t2_state1", 32'(bus.state), 32'd0);
        repeat (20) tick();
        check("t2_retry2", 32'(bus.retry_cnt), 32'd2);
        repeat (20) tick();
        check("t2_retry3", 32'(bus.retry_cnt), 32'd3);
        check("t2_fault", 32'(bus.fault), 32'd1);
        check("t2_dcm_rst", 32'(bus.dcm_rst), 32'd1);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        check("t2_restart_ignored", 32'(bus.state), 32'd4);
        repeat (5) tick();
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        check("t2_clr_state", 32'(bus.state), 32'd0);
        check("t2_clr_retry", 32'(bus.retry_cnt), 32'd0);

        // Glitch during STABLE at timer 5.
        do_reset(1'b1);
        repeat (8) tick();
        bus.locked = 1'b0;
        tick();
        bus.locked = 1'b1;
        repeat (2) tick();
        check("t4_back_wait", 32'(bus.state), 32'd1);
        check("t4_retry", 32'(bus.retry_cnt), 32'd0);
        repeat (8) tick();
        check("t4_still_stable", 32'(bus.state), 32'd2);
        tick();
        check("t4_run", 32'(bus.state), 32'd3);

        // Loss counter saturation.
        do_reset(1'b1);
        for (int i = 0; i < 256; i++) begin
            wait_phase(P_RUN, 40);
            bus.locked = 1'b0;
            tick();
            bus.locked = 1'b1;
            wait_phase(P_RST, 10);
            if (i == 254) check("t5_loss_255", 32'(bus.loss_cnt), 32'hFF);
        end
        check("t5_loss_sat", 32'(bus.loss_cnt), 32'hFF);

        // Asynchronous reset in the middle of STABLE.
        wait_phase(P_STABLE, 20);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("t6_state", 32'(bus.state), 32'd0);
        check("t6_dcm_rst", 32'(bus.dcm_rst), 32'd1);
        check("t6_wb_rst", 32'(bus.wb_rst_out), 32'd1);
        check("t6_ready", 32'(bus.ready), 32'd0);
        check("t6_fault", 32'(bus.fault), 32'd0);
        check("t6_retry", 32'(bus.retry_cnt), 32'd0);
        check("t6_loss", 32'(bus.loss_cnt), 32'd0);

        // Randomized traffic against the model.
        do_reset(1'b1);
        for (int i = 0; i < 3000; i++) begin
            if (bus.locked) begin
                if ($urandom_range(0, 39) == 0) bus.locked = 1'b0;
            end else begin
                if ($urandom_range(0, 79) == 0) bus.locked = 1'b1;
            end
            bus.restart   = ($urandom_range(0, 149) == 0);
            bus.fault_clr = ($urandom_range(0, 199) == 0);
            tick();
            bus.restart   = 1'b0;
            bus.fault_clr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
